// File: rtl/hj_tuple_feeder.sv
// Hash-join front end: tags each tuple with its relation, hashes the key in two stages and steers it to the BUILD or PROBE port.
// Define HJ_FEEDER_IDENTITY_HASH_EN to pass the seeded key straight through as the hash (latency unchanged).
module hj_tuple_feeder #(
  parameter logic [31:0] HASH_SEED   = 32'h0,
  parameter logic [63:0] SERIAL_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic        out_valid_BUILD,
  output logic [63:0] out_data_BUILD,
  output logic [31:0] out_hash_BUILD,
  output logic        out_last_processed_BUILD,
  input  logic        in_ready_BUILD,
  output logic        out_valid_PROBE,
  output logic [63:0] out_data_PROBE,
  output logic [31:0] out_hash_PROBE,
  output logic        out_last_processed_PROBE,
  output logic [63:0] out_serialnum,
  input  logic        in_ready_PROBE,
  output logic [1:0]  phase,
  output logic [31:0] build_count,
  output logic [31:0] probe_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUILD = 2'b01,
    ST_PROBE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t      state_reg;

  // Stage 1: tagged beat plus the partially mixed hash.
  logic        s1_valid_reg;
  logic        s1_tag_reg;
  logic        s1_last_reg;
  logic [63:0] s1_data_reg;
  logic [63:0] s1_serial_reg;
  logic [31:0] s1_hash_reg;

  // Stage 2: output register; the per-port valids double as the phase tag.
  logic        valid_build_reg;
  logic        valid_probe_reg;
  logic        last_reg;
  logic [63:0] data_reg;
  logic [63:0] serial_reg;
  logic [31:0] hash_reg;

  logic [31:0] build_count_reg;
  logic [31:0] probe_count_reg;
  logic [63:0] serial_cnt_reg;

  logic        out_occupied;
  logic        sel_ready;
  logic        pipe_en;
  logic        in_run;
  logic        accept;
  logic        start_run;
  logic [31:0] key;
  logic [31:0] s1_hash_next;
  logic [31:0] s2_hash_next;

  assign out_occupied = valid_build_reg | valid_probe_reg;
  assign sel_ready    = valid_probe_reg ? in_ready_PROBE : in_ready_BUILD;
  assign pipe_en      = ~out_occupied | sel_ready;
  assign in_run       = (state_reg == ST_BUILD) | (state_reg == ST_PROBE);
  assign s_ready      = in_run & pipe_en;
  assign accept       = s_valid & s_ready;
  assign start_run    = start & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));

  assign key = s_data[31:0] ^ HASH_SEED;

`ifdef HJ_FEEDER_IDENTITY_HASH_EN
  assign s1_hash_next = key;
  assign s2_hash_next = s1_hash_reg;
`else
  logic [31:0] key_mix;
  assign key_mix      = key ^ (key >> 16);
  assign s1_hash_next = key_mix * 32'h85EBCA6B;
  assign s2_hash_next = s1_hash_reg ^ (s1_hash_reg >> 13);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) state_reg <= ST_BUILD;
        ST_BUILD: if (accept && s_last) state_reg <= ST_PROBE;
        ST_PROBE: if (accept && s_last) state_reg <= ST_DONE;
        ST_DONE:  if (start) state_reg <= ST_BUILD;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // Counts restart with each run; the serial counter only advances on probe beats.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      build_count_reg <= '0;
      probe_count_reg <= '0;
      serial_cnt_reg  <= '0;
    end else if (start_run) begin
      build_count_reg <= '0;
      probe_count_reg <= '0;
      serial_cnt_reg  <= SERIAL_INIT;
    end else if (accept) begin
      if (state_reg == ST_BUILD) begin
        build_count_reg <= build_count_reg + 32'd1;
      end else begin
        probe_count_reg <= probe_count_reg + 32'd1;
        serial_cnt_reg  <= serial_cnt_reg + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg    <= 1'b0;
      s1_tag_reg      <= 1'b0;
      s1_last_reg     <= 1'b0;
      s1_data_reg     <= '0;
      s1_serial_reg   <= '0;
      s1_hash_reg     <= '0;
      valid_build_reg <= 1'b0;
      valid_probe_reg <= 1'b0;
      last_reg        <= 1'b0;
      data_reg        <= '0;
      serial_reg      <= '0;
      hash_reg        <= '0;
    end else if (pipe_en) begin
      s1_valid_reg    <= accept;
      if (accept) begin
        s1_tag_reg    <= (state_reg == ST_PROBE);
        s1_last_reg   <= s_last;
        s1_data_reg   <= s_data;
        s1_serial_reg <= serial_cnt_reg;
        s1_hash_reg   <= s1_hash_next;
      end
      valid_build_reg <= s1_valid_reg & ~s1_tag_reg;
      valid_probe_reg <= s1_valid_reg & s1_tag_reg;
      if (s1_valid_reg) begin
        last_reg      <= s1_last_reg;
        data_reg      <= s1_data_reg;
        serial_reg    <= s1_serial_reg;
        hash_reg      <= s2_hash_next;
      end
    end
  end

  assign out_valid_BUILD          = valid_build_reg;
  assign out_data_BUILD           = data_reg;
  assign out_hash_BUILD           = hash_reg;
  assign out_last_processed_BUILD = last_reg;
  assign out_valid_PROBE          = valid_probe_reg;
  assign out_data_PROBE           = data_reg;
  assign out_hash_PROBE           = hash_reg;
  assign out_last_processed_PROBE = last_reg;
  assign out_serialnum            = serial_reg;
  assign phase                    = state_reg;
  assign build_count              = build_count_reg;
  assign probe_count              = probe_count_reg;

endmodule

// File: tb/tb_hj_tuple_feeder.sv
// Randomized bench for hj_tuple_feeder: a beat-level scoreboard plus directed runs for hash, serial, stall and reset cases.
module tb_hj_tuple_feeder;
  localparam logic [31:0] SEED  = 32'h0;
  localparam logic [63:0] SINIT = 64'd10;

  logic        clk, resetn, start, s_valid, s_ready, s_last;
  logic [63:0] s_data;
  logic        out_valid_BUILD, out_last_processed_BUILD, in_ready_BUILD;
  logic [63:0] out_data_BUILD;
  logic [31:0] out_hash_BUILD;
  logic        out_valid_PROBE, out_last_processed_PROBE, in_ready_PROBE;
  logic [63:0] out_data_PROBE, out_serialnum;
  logic [31:0] out_hash_PROBE;
  logic [1:0]  phase;
  logic [31:0] build_count, probe_count;

  hj_tuple_feeder #(.HASH_SEED(SEED), .SERIAL_INIT(SINIT)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .out_valid_BUILD(out_valid_BUILD), .out_data_BUILD(out_data_BUILD),
    .out_hash_BUILD(out_hash_BUILD), .out_last_processed_BUILD(out_last_processed_BUILD),
    .in_ready_BUILD(in_ready_BUILD),
    .out_valid_PROBE(out_valid_PROBE), .out_data_PROBE(out_data_PROBE),
    .out_hash_PROBE(out_hash_PROBE), .out_last_processed_PROBE(out_last_processed_PROBE),
    .out_serialnum(out_serialnum), .in_ready_PROBE(in_ready_PROBE),
    .phase(phase), .build_count(build_count), .probe_count(probe_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        tag;
    logic [63:0] ser;
    logic [31:0] hash;
    int          cyc;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] bhash_log[$];
  logic [63:0] pser_log[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [1:0]  ph_m = 2'd0;
  logic [31:0] bcnt_m = 0, pcnt_m = 0;
  logic [63:0] ser_m = 0;
  bit          lat_chk = 0, stall_probe = 0, rand_rdy = 0, acc_flag = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_hash(input logic [31:0] key_in);
    logic [31:0] k;
    logic [63:0] prod;
    logic [31:0] h1;
    k = key_in ^ SEED;
`ifdef HJ_FEEDER_IDENTITY_HASH_EN
    prod = 64'(k);
    h1 = prod[31:0];
    return h1;
`else
    prod = 64'(k ^ (k >> 16)) * 64'h85EBCA6B;
    h1 = prod[31:0];
    return h1 ^ (h1 >> 13);
`endif
  endfunction

  task automatic set_readys();
    in_ready_BUILD = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    in_ready_PROBE = stall_probe ? 1'b0 : (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  // One clock: check outputs, update the reference, advance past the edge.
  task automatic step();
    logic  exp_rdy, in_run, xfer;
    beat_t e;
    #1;
    in_run  = (ph_m == 2'd1) || (ph_m == 2'd2);
    exp_rdy = in_run && (!(out_valid_BUILD || out_valid_PROBE) ||
                         (out_valid_PROBE ? in_ready_PROBE : in_ready_BUILD));
    check_eq("s_ready", s_ready, exp_rdy);
    check_eq("valid_overlap", out_valid_BUILD & out_valid_PROBE, 0);
    if (out_valid_BUILD || out_valid_PROBE) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", {62'd0, out_valid_BUILD, out_valid_PROBE}, 0);
      end else begin
        e = exp_q[0];
        check_eq("port_tag", out_valid_PROBE, e.tag);
        check_eq("data", out_valid_PROBE ? out_data_PROBE : out_data_BUILD, e.data);
        check_eq("hash", out_valid_PROBE ? out_hash_PROBE : out_hash_BUILD, e.hash);
        check_eq("last", out_valid_PROBE ? out_last_processed_PROBE : out_last_processed_BUILD, e.last);
        if (e.tag) check_eq("serial", out_serialnum, e.ser);
        if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 2);
        xfer = out_valid_PROBE ? in_ready_PROBE : in_ready_BUILD;
        if (xfer) begin
          void'(exp_q.pop_front());
          if (out_valid_PROBE) pser_log.push_back(out_serialnum);
          else bhash_log.push_back(out_hash_BUILD);
        end
      end
    end
    acc_flag = 0;
    if (s_valid && exp_rdy) begin
      e.data = s_data;
      e.last = s_last;
      e.tag  = (ph_m == 2'd2);
      e.ser  = ser_m;
      e.hash = ref_hash(s_data[31:0]);
      e.cyc  = cyc;
      exp_q.push_back(e);
      if (e.tag) begin
        pcnt_m = pcnt_m + 1;
        ser_m  = ser_m + 1;
      end else begin
        bcnt_m = bcnt_m + 1;
      end
      if (s_last) ph_m = ph_m + 2'd1;
      acc_flag = 1;
    end
    if (start && !in_run) begin
      ph_m = 2'd1;
      bcnt_m = 0;
      pcnt_m = 0;
      ser_m = SINIT;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_eq("phase", phase, ph_m);
    check_eq("build_count", build_count, bcnt_m);
    check_eq("probe_count", probe_count, pcnt_m);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    s_valid = 1'b1;
    s_data = {$urandom, $urandom};
    s_last = 1'b0;
    set_readys();
    step();
    start = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic push_tuple(input logic [63:0] d, input logic l);
    int tries = 0;
    do begin
      s_valid = 1'b1;
      s_data = d;
      s_last = l;
      set_readys();
      step();
      tries++;
    end while (!acc_flag && tries < 100);
    if (!acc_flag) check_eq("accept_timeout", acc_flag, 1);
    s_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b0;
      s_data = {$urandom, $urandom};
      set_readys();
      step();
    end
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 0;
    stall_probe = 0;
    s_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid_BUILD || out_valid_PROBE) && n < 50) begin
      set_readys();
      step();
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_phase"}, phase, 0);
    check_eq({pfx, "_s_ready"}, s_ready, 0);
    check_eq({pfx, "_valid_b"}, out_valid_BUILD, 0);
    check_eq({pfx, "_valid_p"}, out_valid_PROBE, 0);
    check_eq({pfx, "_bcount"}, build_count, 0);
    check_eq({pfx, "_pcount"}, probe_count, 0);
    check_eq({pfx, "_serial"}, out_serialnum, 0);
    check_eq({pfx, "_hash"}, out_hash_BUILD, 0);
  endtask

  initial begin
    logic [63:0] d;
    resetn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    in_ready_BUILD = 1'b1; in_ready_PROBE = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Run A: known keys, all readys high, latency tracked.
    lat_chk = 1;
    pulse_start();
    push_tuple(64'd0, 1'b0);
    push_tuple(64'd1, 1'b1);
    check_eq("phase_after_build", phase, 2'b10);
    push_tuple({$urandom, $urandom}, 1'b0);
    push_tuple({$urandom, $urandom}, 1'b0);
    push_tuple({$urandom, $urandom}, 1'b1);
    drain();
    lat_chk = 0;
    check_eq("a_bhash_n", bhash_log.size(), 2);
    check_eq("a_pser_n", pser_log.size(), 3);
    if (bhash_log.size() == 2) begin
      check_eq("a_hash_key0", bhash_log[0], 32'h0);
`ifdef HJ_FEEDER_IDENTITY_HASH_EN
      check_eq("a_hash_key1", bhash_log[1], 32'h1);
`else
      check_eq("a_hash_key1", bhash_log[1], 32'h85EFE535);
`endif
    end
    if (pser_log.size() == 3) begin
      check_eq("a_serial0", pser_log[0], 64'd10);
      check_eq("a_serial1", pser_log[1], 64'd11);
      check_eq("a_serial2", pser_log[2], 64'd12);
    end
    check_eq("a_probe_count", probe_count, 3);
    check_eq("a_phase_done", phase, 2'b11);
    bhash_log.delete();
    pser_log.delete();

    // Run B: random traffic and backpressure, with a forced probe stall.
    pulse_start();
    rand_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      push_tuple({$urandom, $urandom}, i == 19);
      if ($urandom_range(0, 2) == 0) idle_cycles(1);
    end
    for (int i = 0; i < 30; i++) begin
      if (i == 10) begin
        rand_rdy = 0;
        push_tuple({$urandom, $urandom}, 1'b0);
        stall_probe = 1;
        d = {$urandom, $urandom};
        for (int j = 0; j < 6; j++) begin
          s_valid = 1'b1; s_data = d; s_last = 1'b0;
          set_readys();
          step();
          if (acc_flag) d = {$urandom, $urandom};
        end
        #1;
        check_eq("stall_s_ready", s_ready, 0);
        check_eq("stall_valid_p", out_valid_PROBE, 1);
        stall_probe = 0;
        rand_rdy = 1;
        s_valid = 1'b0;
        #1;
      end
      push_tuple({$urandom, $urandom}, i == 29);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end
    drain();
    check_eq("b_phase_done", phase, 2'b11);

    // Run C: asynchronous reset with two beats in flight, then a fresh run.
    bhash_log.delete();
    pser_log.delete();
    pulse_start();
    push_tuple({$urandom, $urandom}, 1'b0);
    push_tuple({$urandom, $urandom}, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    ph_m = 2'd0; bcnt_m = 0; pcnt_m = 0; ser_m = 0;
    @(negedge clk);
    resetn = 1'b1;
    pulse_start();
    push_tuple({32'hABCD0000, 32'h00001234}, 1'b1);
    push_tuple({$urandom, $urandom}, 1'b0);
    push_tuple({$urandom, $urandom}, 1'b1);
    drain();
    check_eq("c_bhash_n", bhash_log.size(), 1);
    check_eq("c_pser_n", pser_log.size(), 2);
    if (bhash_log.size() == 1) begin
`ifdef HJ_FEEDER_IDENTITY_HASH_EN
      check_eq("c_hash_1234", bhash_log[0], 32'h00001234);
`else
      check_eq("c_hash_1234", bhash_log[0], 32'hC826E2B9);
`endif
    end
    if (pser_log.size() == 2) begin
      check_eq("c_serial_restart", pser_log[0], 64'd10);
      check_eq("c_serial_next", pser_log[1], 64'd11);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hj_tuple_feeder.md
# hj_tuple_feeder

Front-end stream source for the partitioned hash join. It accepts one raw 64-bit tuple stream carrying the build relation followed by the probe relation. For each tuple it computes the 32-bit bucket hash from the key (`tuple[31:0]`) and tags the beat with its phase. It then drives the hash table's BUILD and PROBE input ports, including hash, last marker and, for probe tuples, a sequential 64-bit serial number.

## Interface
Parameters:
- `HASH_SEED`, default `32'h0`: XORed into the key before hashing.
- `SERIAL_INIT`, default `64'h0`: serial number given to the first probe tuple of a run.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a run. Honoured only in IDLE or DONE.
- `s_valid`  in  1  input tuple valid.
- `s_ready`  out  1  input tuple accepted when `s_valid & s_ready` at an edge.
- `s_data`  in  64  input tuple; key is `[31:0]`.
- `s_last`  in  1  marks the final tuple of the current relation.
- `out_valid_BUILD`, `out_data_BUILD[63:0]`, `out_hash_BUILD[31:0]`, `out_last_processed_BUILD`  out  build beat.
- `in_ready_BUILD`  in  1  hash table can take a build beat.
- `out_valid_PROBE`, `out_data_PROBE[63:0]`, `out_hash_PROBE[31:0]`, `out_last_processed_PROBE`, `out_serialnum[63:0]`  out  probe beat.
- `in_ready_PROBE`  in  1  hash table can take a probe beat.
- `phase`  out  2  00 IDLE, 01 BUILD, 10 PROBE, 11 DONE.
- `build_count`, `probe_count`  out  32 each  tuples accepted in the current run; wrap modulo 2^32.

## Operation
- **States:**
  - IDLE --start--> BUILD.
  - BUILD --accepted beat with `s_last`--> PROBE.
  - PROBE --accepted beat with `s_last`--> DONE.
  - DONE --start--> BUILD.
  - `start` in BUILD or PROBE is ignored.
- **On entering BUILD:** the counts clear to 0 and the serial counter loads `SERIAL_INIT`.
- **Phase tag:** each accepted beat takes the state at acceptance (BUILD→0, PROBE→1) and carries it through the pipeline. Build and probe beats may be in flight together, and order is always preserved.
- **`s_ready`:** equals `(state==BUILD|state==PROBE) & pipe_en`.
  - `pipe_en = ~out_occupied | sel_ready`.
  - `sel_ready` is `in_ready_BUILD` if the output-stage tag is 0, else `in_ready_PROBE`.
- **Hash, 2 stages:**
  - `k = s_data[31:0] ^ HASH_SEED`.
  - S1: `h1 = (k ^ (k>>16)) * 32'h85EBCA6B`, keeping the low 32 bits.
  - S2 (output register): `h = h1 ^ (h1>>13)`.
- **Serial numbers:** a probe beat takes the current serial counter at acceptance, then the counter increments. It wraps 64-bit (`FFFF_FFFF_FFFF_FFFF` → 0). Build beats do not advance it.
- **Output routing:** only the output port matching the tag may assert valid; the other port's valid is 0. Data, hash and last appear on both port groups; the consumer qualifies them by valid.
- **Last marker:** `out_last_processed_*` mirrors the beat's `s_last`.

## Timing
- **Reset:** all outputs are 0 (`phase`=00, `s_ready`=0, both valids 0, counts 0, `out_serialnum` 0). The pipeline is flushed.
- **Reset mid-run:** in-flight beats are discarded and the state returns to IDLE.
- **Latency:** a beat accepted at edge E0 is presented after edge E2 when not stalled.
- **Throughput:** 1 beat/cycle.
- **Stall:** when the output stage is occupied and its selected ready is low, both stages and all outputs hold their values. `s_ready` drops combinationally in that same cycle. No bubbles are inserted and no beat is dropped or duplicated.
- **Valid stability:** a valid output beat holds data, hash, last and serial stable until it is accepted.
- **Counter updates:** `build_count`/`probe_count` update at the accept edge.
- **Last-beat transition:** the phase change happens at the edge that accepts the `s_last` beat. In the cycle after the probe last is accepted, `s_ready`=0.
- **Start edge:** `start` and `s_valid` in the same IDLE cycle means no accept that cycle. The first accept happens in BUILD.

## Configuration
- Macro `HJ_FEEDER_IDENTITY_HASH_EN`.
- **Defined:** the hash equals `k` unmodified (the S1 multiply is removed). Latency stays at 2 edges, for debug/bring-up with predictable buckets.
- **Undefined:** the multiplicative hash above is used.

## Test plan
- Reset, start, build keys 0 and 1 with `s_last` on key 1, `HASH_SEED`=0 and all readys 1 → BUILD port shows hashes `32'h0` and `32'h85EFE535`; last=1 on the second beat; `phase`=PROBE.
- Probe 3 tuples with `SERIAL_INIT`=10 → `out_serialnum` reads 10, 11, 12; `probe_count`=3; `phase`=DONE after the third; PROBE valid only.
- Hold `in_ready_PROBE`=0 for 5 cycles mid-stream → outputs frozen, `s_ready`=0, no loss. The full sequence is intact after release.
- Build last immediately followed by a probe tuple → build beat on BUILD port, probe beat on PROBE port one cycle later, with no overlap of valids.
- Assert `resetn`=0 asynchronously with 2 beats in flight → all outputs 0 immediately; next run restarts at `SERIAL_INIT`.
- With `HJ_FEEDER_IDENTITY_HASH_EN` defined and key `32'h1234` → hash `32'h1234` at 2-edge latency.
